// File: rtl/multi_channel_energy_logger_if.sv
// Sample-in / result-out handshake bundle for multi_channel_energy_logger.
// Both directions use valid/ready: a transfer happens on a rising clock edge
// where valid and ready are both 1; the producer holds its payload stable
// while valid=1 and ready=0, and ready may depend combinationally on the
// other side's signals.
interface multi_channel_energy_logger_if #(
  parameter int DATA_W = 8,
  parameter int CH_W   = 2
);
  logic              in_valid;
  logic              in_ready;
  logic [CH_W-1:0]   in_ch;
  logic [DATA_W-1:0] in_data;
  logic              in_err;
  logic              out_valid;
  logic              out_ready;
  logic [CH_W-1:0]   out_ch;
  logic [DATA_W-1:0] out_avg;
  logic [DATA_W-1:0] out_min;
  logic [DATA_W-1:0] out_max;

  modport master (
    output in_valid, in_ch, in_data, out_ready,
    input  in_ready, in_err, out_valid, out_ch, out_avg, out_min, out_max
  );

  modport slave (
    input  in_valid, in_ch, in_data, out_ready,
    output in_ready, in_err, out_valid, out_ch, out_avg, out_min, out_max
  );
endinterface

// File: rtl/multi_channel_energy_logger.sv
// Per-channel windowed statistics collector. Each channel accumulates
// 2**LOG2_WIN samples, then publishes average/min/max through a one-deep
// output register and may latch a sticky over-threshold alarm.
module multi_channel_energy_logger #(
  parameter int DATA_W   = 8,
  parameter int NUM_CH   = 4,
  parameter int CH_W     = 2,
  parameter int LOG2_WIN = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clr,
  input  logic [DATA_W-1:0]    thresh,
  output logic [NUM_CH-1:0]    alarm,
  multi_channel_energy_logger_if.slave bus
);

  localparam int ACC_W = DATA_W + LOG2_WIN;
  localparam int CNT_W = LOG2_WIN + 1;
  localparam int WIN   = 1 << LOG2_WIN;

  logic [ACC_W-1:0]  acc_q [NUM_CH];
  logic [CNT_W-1:0]  cnt_q [NUM_CH];
  logic [DATA_W-1:0] min_q [NUM_CH];
  logic [DATA_W-1:0] max_q [NUM_CH];

  logic              accept;
  logic              ch_ok;
  logic              take;
  logic              done;
  logic [ACC_W-1:0]  sel_acc;
  logic [CNT_W-1:0]  sel_cnt;
  logic [DATA_W-1:0] sel_min;
  logic [DATA_W-1:0] sel_max;
  logic [ACC_W-1:0]  new_acc;
  logic [CNT_W-1:0]  new_cnt;
  logic [DATA_W-1:0] new_min;
  logic [DATA_W-1:0] new_max;
  logic [DATA_W-1:0] new_avg;

  // The only stall source is a result that the consumer has not yet taken.
  assign bus.in_ready = ~(bus.out_valid & ~bus.out_ready);

  // Select the tagged channel's state and compute its post-sample values.
  always_comb begin
    accept  = bus.in_valid & bus.in_ready;
    ch_ok   = 1'b0;
    sel_acc = '0;
    sel_cnt = '0;
    sel_min = '0;
    sel_max = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (bus.in_ch == CH_W'(c)) begin
        ch_ok   = 1'b1;
        sel_acc = acc_q[c];
        sel_cnt = cnt_q[c];
        sel_min = min_q[c];
        sel_max = max_q[c];
      end
    end
    new_acc = sel_acc + ACC_W'(bus.in_data);
    new_cnt = sel_cnt + CNT_W'(1);
    new_min = ((sel_cnt == '0) || (bus.in_data < sel_min)) ? bus.in_data : sel_min;
    new_max = ((sel_cnt == '0) || (bus.in_data > sel_max)) ? bus.in_data : sel_max;
    new_avg = DATA_W'(new_acc >> LOG2_WIN);
    // A sample seen together with clr is consumed but never counted.
    take    = accept & ~clr & ch_ok;
    done    = take & (new_cnt == CNT_W'(WIN));
  end

  // Channel windows, sticky alarms and the one-deep result register.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int c = 0; c < NUM_CH; c++) begin
        acc_q[c] <= '0;
        cnt_q[c] <= '0;
        min_q[c] <= '0;
        max_q[c] <= '0;
      end
      alarm         <= '0;
      bus.in_err    <= 1'b0;
      bus.out_valid <= 1'b0;
      bus.out_ch    <= '0;
      bus.out_avg   <= '0;
      bus.out_min   <= '0;
      bus.out_max   <= '0;
    end else begin
      bus.in_err <= accept & ~ch_ok;
      for (int c = 0; c < NUM_CH; c++) begin
        if (clr) begin
          acc_q[c] <= '0;
          cnt_q[c] <= '0;
          min_q[c] <= '0;
          max_q[c] <= '0;
          alarm[c] <= 1'b0;
        end else if (take && (bus.in_ch == CH_W'(c))) begin
          acc_q[c] <= done ? '0 : new_acc;
          cnt_q[c] <= done ? '0 : new_cnt;
          min_q[c] <= new_min;
          max_q[c] <= new_max;
          if (done && (new_avg > thresh)) alarm[c] <= 1'b1;
        end
      end
      // A new result can only load when the register is empty or being drained.
      if (done) begin
        bus.out_valid <= 1'b1;
        bus.out_ch    <= bus.in_ch;
        bus.out_avg   <= new_avg;
        bus.out_min   <= new_min;
        bus.out_max   <= new_max;
      end else if (bus.out_ready) begin
        bus.out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_multi_channel_energy_logger.sv
// Directed bench for multi_channel_energy_logger: a default 4-channel
// instance plus a 3-channel instance for out-of-range tag handling.
module tb_multi_channel_energy_logger;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       clr = 1'b0;
  logic [7:0] thresh = 8'd255;
  logic [3:0] alarm;
  logic       clr3 = 1'b0;
  logic [7:0] thresh3 = 8'd255;
  logic [2:0] alarm3;
  int         checks = 0;
  int         failures = 0;

  multi_channel_energy_logger_if #(.DATA_W(8), .CH_W(2)) bus ();
  multi_channel_energy_logger_if #(.DATA_W(8), .CH_W(2)) bus3 ();

  multi_channel_energy_logger #(.DATA_W(8), .NUM_CH(4), .CH_W(2), .LOG2_WIN(3)) dut (
    .clk(clk), .rst(rst), .clr(clr), .thresh(thresh), .alarm(alarm), .bus(bus)
  );

  multi_channel_energy_logger #(.DATA_W(8), .NUM_CH(3), .CH_W(2), .LOG2_WIN(3)) dut3 (
    .clk(clk), .rst(rst), .clr(clr3), .thresh(thresh3), .alarm(alarm3), .bus(bus3)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [1:0] ch, input logic [7:0] d);
    bus.in_valid = 1'b1;
    bus.in_ch    = ch;
    bus.in_data  = d;
    tick();
    bus.in_valid = 1'b0;
  endtask

  task automatic send3(input logic [1:0] ch, input logic [7:0] d);
    bus3.in_valid = 1'b1;
    bus3.in_ch    = ch;
    bus3.in_data  = d;
    tick();
    bus3.in_valid = 1'b0;
  endtask

  task automatic test_reset();
    bus.in_valid = 0; bus.in_ch = 0; bus.in_data = 0; bus.out_ready = 1;
    bus3.in_valid = 0; bus3.in_ch = 0; bus3.in_data = 0; bus3.out_ready = 1;
    rst = 1;
    tick();
    tick();
    checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", bus.out_valid); end
    checks++; if (bus.in_err !== 1'b0) begin failures++; $display("FAIL reset_in_err got=%b exp=0", bus.in_err); end
    checks++; if (alarm !== 4'b0000) begin failures++; $display("FAIL reset_alarm got=%b exp=0000", alarm); end
    checks++; if ({bus.out_ch, bus.out_avg, bus.out_min, bus.out_max} !== 26'd0) begin failures++; $display("FAIL reset_out_fields got=%h exp=0", {bus.out_ch, bus.out_avg, bus.out_min, bus.out_max}); end
    checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", bus.in_ready); end
    rst = 0;
    tick();
  endtask

  // T1: 10..80 on ch0 -> avg 45, min 10, max 80
  task automatic test_window();
    thresh = 8'd255;
    bus.out_ready = 1;
    for (int i = 1; i <= 7; i++) send(2'd0, 8'(i * 10));
    checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL t1_early_valid got=%b exp=0", bus.out_valid); end
    send(2'd0, 8'd80);
    checks++; if (bus.out_valid !== 1'b1) begin failures++; $display("FAIL t1_valid got=%b exp=1", bus.out_valid); end
    checks++; if (bus.out_ch !== 2'd0) begin failures++; $display("FAIL t1_ch got=%0d exp=0", bus.out_ch); end
    checks++; if (bus.out_avg !== 8'd45) begin failures++; $display("FAIL t1_avg got=%0d exp=45", bus.out_avg); end
    checks++; if (bus.out_min !== 8'd10) begin failures++; $display("FAIL t1_min got=%0d exp=10", bus.out_min); end
    checks++; if (bus.out_max !== 8'd80) begin failures++; $display("FAIL t1_max got=%0d exp=80", bus.out_max); end
    tick();
    checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL t1_drain got=%b exp=0", bus.out_valid); end
  endtask

  // T2: interleaved ch1=200 and ch2=5 with thresh 100
  task automatic test_interleave();
    thresh = 8'd100;
    bus.out_ready = 1;
    for (int i = 0; i < 8; i++) begin
      send(2'd1, 8'd200);
      if (i == 7) begin
        checks++; if (bus.out_valid !== 1'b1 || bus.out_ch !== 2'd1 || bus.out_avg !== 8'd200) begin failures++; $display("FAIL t2_ch1 got=v%b ch%0d avg%0d exp=v1 ch1 avg200", bus.out_valid, bus.out_ch, bus.out_avg); end
      end
      send(2'd2, 8'd5);
    end
    checks++; if (bus.out_valid !== 1'b1 || bus.out_ch !== 2'd2) begin failures++; $display("FAIL t2_ch2_id got=v%b ch%0d exp=v1 ch2", bus.out_valid, bus.out_ch); end
    checks++; if (bus.out_avg !== 8'd5 || bus.out_min !== 8'd5 || bus.out_max !== 8'd5) begin failures++; $display("FAIL t2_ch2_stats got=%0d/%0d/%0d exp=5/5/5", bus.out_avg, bus.out_min, bus.out_max); end
    checks++; if (alarm !== 4'b0010) begin failures++; $display("FAIL t2_alarm got=%b exp=0010", alarm); end
    tick();
  endtask

  // T3: stall with a pending result, then back-to-back load on drain
  task automatic test_back_to_back();
    thresh = 8'd255;
    bus.out_ready = 1;
    for (int i = 0; i < 7; i++) send(2'd1, 8'd40);
    bus.out_ready = 0;
    for (int i = 0; i < 8; i++) send(2'd0, 8'(i * 3));
    checks++; if (bus.out_valid !== 1'b1 || bus.out_avg !== 8'd10 || bus.out_min !== 8'd0 || bus.out_max !== 8'd21) begin failures++; $display("FAIL t3_first got=v%b %0d/%0d/%0d exp=v1 10/0/21", bus.out_valid, bus.out_avg, bus.out_min, bus.out_max); end
    bus.in_valid = 1; bus.in_ch = 2'd1; bus.in_data = 8'd40;
    #1;
    checks++; if (bus.in_ready !== 1'b0) begin failures++; $display("FAIL t3_in_ready got=%b exp=0", bus.in_ready); end
    for (int i = 0; i < 3; i++) tick();
    checks++; if (bus.out_valid !== 1'b1 || bus.out_ch !== 2'd0 || bus.out_avg !== 8'd10 || bus.out_max !== 8'd21) begin failures++; $display("FAIL t3_hold got=v%b ch%0d avg%0d max%0d exp=v1 ch0 avg10 max21", bus.out_valid, bus.out_ch, bus.out_avg, bus.out_max); end
    bus.out_ready = 1; bus.in_data = 8'd48;
    tick();
    bus.in_valid = 0;
    checks++; if (bus.out_valid !== 1'b1 || bus.out_ch !== 2'd1) begin failures++; $display("FAIL t3_b2b_id got=v%b ch%0d exp=v1 ch1", bus.out_valid, bus.out_ch); end
    checks++; if (bus.out_avg !== 8'd41 || bus.out_min !== 8'd40 || bus.out_max !== 8'd48) begin failures++; $display("FAIL t3_b2b_stats got=%0d/%0d/%0d exp=41/40/48", bus.out_avg, bus.out_min, bus.out_max); end
    tick();
    checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL t3_drain got=%b exp=0", bus.out_valid); end
  endtask

  // T4: partial window on ch3, clr with a sample, then a clean window of 7s
  task automatic test_clear();
    thresh = 8'd10;
    bus.out_ready = 1;
    for (int i = 0; i < 4; i++) send(2'd3, 8'd100);
    clr = 1;
    send(2'd3, 8'd250);
    clr = 0;
    checks++; if (alarm !== 4'b0000) begin failures++; $display("FAIL t4_alarm_clr got=%b exp=0000", alarm); end
    for (int i = 0; i < 8; i++) send(2'd3, 8'd7);
    checks++; if (bus.out_valid !== 1'b1 || bus.out_ch !== 2'd3) begin failures++; $display("FAIL t4_id got=v%b ch%0d exp=v1 ch3", bus.out_valid, bus.out_ch); end
    checks++; if (bus.out_avg !== 8'd7 || bus.out_min !== 8'd7 || bus.out_max !== 8'd7) begin failures++; $display("FAIL t4_stats got=%0d/%0d/%0d exp=7/7/7", bus.out_avg, bus.out_min, bus.out_max); end
    checks++; if (alarm !== 4'b0000) begin failures++; $display("FAIL t4_alarm got=%b exp=0000", alarm); end
    tick();
  endtask

  // T5: out-of-range tag on the 3-channel instance
  task automatic test_bad_channel();
    for (int i = 0; i < 3; i++) send3(2'd0, 8'd16);
    send3(2'd3, 8'd99);
    checks++; if (bus3.in_err !== 1'b1) begin failures++; $display("FAIL t5_err_pulse got=%b exp=1", bus3.in_err); end
    checks++; if (bus3.out_valid !== 1'b0) begin failures++; $display("FAIL t5_no_result got=%b exp=0", bus3.out_valid); end
    tick();
    checks++; if (bus3.in_err !== 1'b0) begin failures++; $display("FAIL t5_err_clear got=%b exp=0", bus3.in_err); end
    for (int i = 0; i < 4; i++) send3(2'd0, 8'd16);
    checks++; if (bus3.out_valid !== 1'b0) begin failures++; $display("FAIL t5_count_early got=%b exp=0", bus3.out_valid); end
    send3(2'd0, 8'd16);
    checks++; if (bus3.out_valid !== 1'b1 || bus3.out_avg !== 8'd16 || bus3.out_max !== 8'd16) begin failures++; $display("FAIL t5_window got=v%b avg%0d max%0d exp=v1 avg16 max16", bus3.out_valid, bus3.out_avg, bus3.out_max); end
    tick();
  endtask

  // T6: reset in the middle of a window with a result pending
  task automatic test_reset_mid();
    thresh = 8'd20;
    bus.out_ready = 1;
    for (int i = 0; i < 3; i++) send(2'd0, 8'd200);
    bus.out_ready = 0;
    for (int i = 0; i < 8; i++) send(2'd2, 8'd50);
    checks++; if (bus.out_valid !== 1'b1 || alarm !== 4'b0100) begin failures++; $display("FAIL t6_pre got=v%b alarm%b exp=v1 alarm0100", bus.out_valid, alarm); end
    rst = 1;
    tick();
    rst = 0;
    checks++; if (bus.out_valid !== 1'b0 || alarm !== 4'b0000 || bus.in_err !== 1'b0) begin failures++; $display("FAIL t6_rst_ctl got=v%b alarm%b err%b exp=v0 alarm0000 err0", bus.out_valid, alarm, bus.in_err); end
    checks++; if ({bus.out_ch, bus.out_avg, bus.out_min, bus.out_max} !== 26'd0) begin failures++; $display("FAIL t6_rst_fields got=%h exp=0", {bus.out_ch, bus.out_avg, bus.out_min, bus.out_max}); end
    bus.out_ready = 1;
    for (int i = 1; i <= 8; i++) send(2'd0, 8'(i));
    checks++; if (bus.out_valid !== 1'b1 || bus.out_avg !== 8'd4 || bus.out_min !== 8'd1 || bus.out_max !== 8'd8) begin failures++; $display("FAIL t6_fresh got=v%b %0d/%0d/%0d exp=v1 4/1/8", bus.out_valid, bus.out_avg, bus.out_min, bus.out_max); end
    tick();
  endtask

  // test sequence and final report
  initial begin
    test_reset();
    test_window();
    test_interleave();
    test_back_to_back();
    test_clear();
    test_bad_channel();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
